ysyx_220053_instr_to_imm: RTL and testbench

//  Immediate generator for the RV64 decode stage (IDU). Extracts the immediate

---
 rtl/ysyx_220053_pkg.sv | 20 ++
 rtl/ysyx_220053_sext.sv | 19 +
 rtl/ysyx_220053_instr_to_imm.sv | 87 ++++++++
 tb/tb_ysyx_220053_instr_to_imm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_pkg.sv
// Shared decode definitions: immediate format select codes and the XLEN default.
// The decode controller and the immediate generator both import this package.
package ysyx_220053_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int INSTR_W      = 32;
    localparam int EXT_OP_W     = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_I     = 3'd0,
        EXT_U     = 3'd1,
        EXT_S     = 3'd2,
        EXT_B     = 3'd3,
        EXT_J     = 3'd4,
        EXT_SHAMT = 3'd5,
        EXT_ZIMM  = 3'd6,
        EXT_RSVD  = 3'd7
    } ext_op_e;

endpackage

// File: rtl/ysyx_220053_sext.sv
// Parameterised sign-extender: replicates the MSB of a narrow field up to OUT_W bits.
// When the field is at least as wide as the output it is simply truncated.
module ysyx_220053_sext #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 64
) (
    input  logic [IN_W-1:0]  field,
    output logic [OUT_W-1:0] result
);

    generate
        if (OUT_W > IN_W) begin : g_extend
            assign result = {{(OUT_W-IN_W){field[IN_W-1]}}, field};
        end else begin : g_trunc
            assign result = field[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/ysyx_220053_instr_to_imm.sv
// RV64 IDU immediate generator: combinational extended immediate plus a
// one-cycle registered copy with valid and error flags.
module ysyx_220053_instr_to_imm
    import ysyx_220053_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [EXT_OP_W-1:0] ExtOp,
    input  logic                valid_i,
    output logic [XLEN-1:0]     imm,
    output logic                ext_err,
    output logic [XLEN-1:0]     imm_q,
    output logic                valid_q,
    output logic                err_q
);

    logic [XLEN-1:0] imm_i_fmt;
    logic [XLEN-1:0] imm_u_fmt;
    logic [XLEN-1:0] imm_s_fmt;
    logic [XLEN-1:0] imm_b_fmt;
    logic [XLEN-1:0] imm_j_fmt;
    ext_op_e         op;

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    assign op = ext_op_e'(ExtOp);

    ysyx_220053_sext #(.IN_W(12), .OUT_W(XLEN)) u_sext_i (
        .field  (instr_i[31:20]),
        .result (imm_i_fmt)
    );

    ysyx_220053_sext #(.IN_W(32), .OUT_W(XLEN)) u_sext_u (
        .field  ({instr_i[31:12], 12'b0}),
        .result (imm_u_fmt)
    );

    ysyx_220053_sext #(.IN_W(12), .OUT_W(XLEN)) u_sext_s (
        .field  ({instr_i[31:25], instr_i[11:7]}),
        .result (imm_s_fmt)
    );

    ysyx_220053_sext #(.IN_W(13), .OUT_W(XLEN)) u_sext_b (
        .field  ({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}),
        .result (imm_b_fmt)
    );

    ysyx_220053_sext #(.IN_W(21), .OUT_W(XLEN)) u_sext_j (
        .field  ({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}),
        .result (imm_j_fmt)
    );

    always_comb begin
        imm     = '0;
        ext_err = 1'b0;
        case (op)
            EXT_I:     imm = imm_i_fmt;
            EXT_U:     imm = imm_u_fmt;
            EXT_S:     imm = imm_s_fmt;
            EXT_B:     imm = imm_b_fmt;
            EXT_J:     imm = imm_j_fmt;
            EXT_SHAMT: imm[5:0] = instr_i[25:20];
            EXT_ZIMM:  imm[4:0] = instr_i[19:15];
            EXT_RSVD:  ext_err = 1'b1;
            default:   ext_err = 1'b1;
        endcase
    end

    // Capture every cycle; downstream logic qualifies with valid_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            imm_q   <= imm;
            valid_q <= valid_i;
            err_q   <= ext_err & valid_i;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_instr_to_imm.sv
// Self-checking bench for the immediate generator: directed vector table,
// randomized comparison against an arithmetic reference model, reset sequences.
module tb_ysyx_220053_instr_to_imm;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic [2:0]  ExtOp;
    logic        valid_i;
    logic [63:0] imm;
    logic        ext_err;
    logic [63:0] imm_q;
    logic        valid_q;
    logic        err_q;

    int checks   = 0;
    int failures = 0;

    ysyx_220053_instr_to_imm #(.XLEN(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .instr_i (instr_i),
        .ExtOp   (ExtOp),
        .valid_i (valid_i),
        .imm     (imm),
        .ext_err (ext_err),
        .imm_q   (imm_q),
        .valid_q (valid_q),
        .err_q   (err_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  op;
        logic [63:0] exp_imm;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two's-complement interpretation of a w-bit field.
    function automatic longint sx(input longint field, input int w);
        if (field >= (longint'(1) << (w - 1)))
            return field - (longint'(1) << w);
        return field;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] in, input logic [2:0] op);
        longint v;
        case (op)
            3'd0: v = sx(longint'(in[31:20]), 12);
            3'd1: v = sx(longint'(in[31:12]), 20) * 4096;
            3'd2: v = sx(longint'(in[31:25]) * 32 + longint'(in[11:7]), 12);
            3'd3: v = sx(longint'(in[31]) * 4096 + longint'(in[7]) * 2048
                         + longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2, 13);
            3'd4: v = sx(longint'(in[31]) * 1048576 + longint'(in[19:12]) * 4096
                         + longint'(in[20]) * 2048 + longint'(in[30:21]) * 2, 21);
            3'd5: v = longint'(in[25:20]);
            3'd6: v = longint'(in[19:15]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    initial begin
        vec_t vecs[$];
        logic [31:0] r_instr;
        logic [2:0]  r_op;
        logic        r_valid;

        vecs.push_back('{32'h00100073, 3'd0, 64'h1, 1'b0});
        vecs.push_back('{32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back('{32'h7FF00093, 3'd0, 64'h7FF, 1'b0});
        vecs.push_back('{32'h800000B7, 3'd1, 64'hFFFF_FFFF_8000_0000, 1'b0});
        vecs.push_back('{32'h7FFFF0B7, 3'd1, 64'h0000_0000_7FFF_F000, 1'b0});
        vecs.push_back('{32'hFE112E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        vecs.push_back('{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        vecs.push_back('{32'h0080006F, 3'd4, 64'h8, 1'b0});
        vecs.push_back('{32'hFFFFFFEF, 3'd4, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{32'h03F09093, 3'd5, 64'd63, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 3'd5, 64'd63, 1'b0});
        vecs.push_back('{32'h000F8000, 3'd6, 64'd31, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 3'd6, 64'd31, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 3'd7, 64'h0, 1'b1});

        rst     = 1'b1;
        instr_i = 32'h0;
        ExtOp   = 3'd0;
        valid_i = 1'b0;
        #2;
        check("reset_imm_q", imm_q, 64'h0);
        check("reset_valid_q", 64'(valid_q), 64'h0);
        check("reset_err_q", 64'(err_q), 64'h0);

        // Combinational table, checked while still in reset.
        for (int i = 0; i < vecs.size(); i++) begin
            instr_i = vecs[i].instr;
            ExtOp   = vecs[i].op;
            #1;
            check($sformatf("vec%0d_imm", i), imm, vecs[i].exp_imm);
            check($sformatf("vec%0d_err", i), 64'(ext_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_model", i), imm, ref_imm(vecs[i].instr, vecs[i].op));
        end
        check("held_imm_q_in_reset", imm_q, 64'h0);

        @(negedge clk);
        rst = 1'b0;

        // Registered path: ebreak with valid_i.
        @(negedge clk);
        instr_i = 32'h00100073;
        ExtOp   = 3'd0;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        check("reg_imm_q", imm_q, 64'h1);
        check("reg_valid_q", 64'(valid_q), 64'h1);
        check("reg_err_q", 64'(err_q), 64'h0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_imm_q", imm_q, 64'h0);
        check("async_rst_valid_q", 64'(valid_q), 64'h0);
        @(negedge clk);
        instr_i = 32'hFFF00093;
        rst     = 1'b0;
        #1;
        check("no_capture_before_edge", imm_q, 64'h0);
        @(posedge clk);
        #1;
        check("first_capture_after_rst", imm_q, 64'hFFFF_FFFF_FFFF_FFFF);

        // err_q only asserts with valid_i.
        @(negedge clk);
        ExtOp   = 3'd7;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("err_q_invalid", 64'(err_q), 64'h0);
        check("valid_q_low", 64'(valid_q), 64'h0);
        @(negedge clk);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        check("err_q_valid", 64'(err_q), 64'h1);
        check("imm_q_rsvd", imm_q, 64'h0);

        // Randomized comparison against the reference model.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            r_instr = $urandom;
            r_op    = 3'($urandom_range(0, 7));
            r_valid = 1'($urandom_range(0, 1));
            instr_i = r_instr;
            ExtOp   = r_op;
            valid_i = r_valid;
            #1;
            check("rand_imm", imm, ref_imm(r_instr, r_op));
            check("rand_err", 64'(ext_err), 64'(r_op == 3'd7));
            @(posedge clk);
            #1;
            check("rand_imm_q", imm_q, ref_imm(r_instr, r_op));
            check("rand_valid_q", 64'(valid_q), 64'(r_valid));
            check("rand_err_q", 64'(err_q), 64'((r_op == 3'd7) && r_valid));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
